// File: rtl/cnna_mul_arb_pkg.sv
// Shared constants and helpers for the cnna shared-multiplier arbiter.
//   A_W/B_W   : operand widths (unsigned multiplicand / multiplier)
//   P_W       : response product width
//   FULL_W    : full-precision product width
//   clog2_fn  : index width needed for n requesters
//   oh2idx    : one-hot (up to MAX_REQ bits) to binary index
package cnna_mul_arb_pkg;

    localparam int unsigned A_W      = 15;
    localparam int unsigned B_W      = 13;
    localparam int unsigned P_W      = 16;
    localparam int unsigned FULL_W   = 28;
    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned MAX_ID_W = 3;

    // Smallest w with 2**w >= n.
    function automatic int unsigned clog2_fn(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    // OR-reduce the indices of set bits; exact for one-hot or zero inputs.
    function automatic logic [MAX_ID_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_ID_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= MAX_ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cnna_mul_15x13.sv
// Single-stage unsigned 15x13 multiplier producing a 16-bit result.
// With CNNA_MUL_SAT_EN defined the result saturates to all-ones when the
// full product exceeds 16 bits and sat_o reports it; otherwise it truncates.
//   a_i   : 15-bit unsigned multiplicand
//   b_i   : 13-bit unsigned multiplier
//   p_o   : 16-bit product
//   sat_o : saturation indicator (CNNA_MUL_SAT_EN only)
module cnna_mul_15x13
    import cnna_mul_arb_pkg::*;
(
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
`ifdef CNNA_MUL_SAT_EN
    output logic           sat_o,
`endif
    output logic [P_W-1:0] p_o
);

`ifdef CNNA_MUL_SAT_EN
    logic [FULL_W-1:0] full;

    assign full  = FULL_W'(a_i) * FULL_W'(b_i);
    assign sat_o = |full[FULL_W-1:P_W];
    assign p_o   = sat_o ? '1 : full[P_W-1:0];
`else
    // Low 16 bits of a product only depend on the low 16 bits of the operands.
    assign p_o = P_W'(a_i) * P_W'(b_i);
`endif

endmodule

// File: rtl/cnna_rr_pick.sv
// Combinational round-robin pick: rotate requests so rr_ptr_i sits at bit 0,
// take the lowest set bit, rotate the grant back.
//   req_i       : request vector
//   rr_ptr_i    : highest-priority index this cycle
//   grant_o     : one-hot grant (zero when no request)
//   grant_idx_o : binary index of grant_o
module cnna_rr_pick
    import cnna_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = clog2_fn(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_gnt;
    logic [ID_W:0]      back_sh;

    always_comb begin
        rot         = NUM_REQ'({req_i, req_i} >> rr_ptr_i);
        rot_gnt     = rot & (~rot + NUM_REQ'(1));
        // Shifting by NUM_REQ - ptr rotates left by ptr; ptr=0 picks the upper copy.
        back_sh     = (ID_W + 1)'(NUM_REQ) - (ID_W + 1)'(rr_ptr_i);
        grant_o     = NUM_REQ'({rot_gnt, rot_gnt} >> back_sh);
        grant_idx_o = ID_W'(oh2idx(MAX_REQ'(grant_o)));
    end

endmodule

// File: rtl/cnna_mul_share_arb.sv
// Round-robin arbiter sharing one 15x13 multiplier among NUM_REQ requesters.
// Accepted operand pairs produce a registered 16-bit product, tagged with the
// requester index, one cycle later.
// Optional feature macro: CNNA_MUL_SAT_EN (saturating result + sat_flag port).
//   ap_clk, ap_rst          : clock, asynchronous active-high reset
//   req_valid / req_ready   : per-requester handshake (ready at most one-hot)
//   req_a / req_b           : packed operands, requester i at [W*i +: W]
//   resp_valid / resp_ready : response handshake
//   resp_data / resp_id     : product and originating requester
//   sat_flag                : product saturated (CNNA_MUL_SAT_EN only)
//   op_cnt                  : accepted operations, wrapping
module cnna_mul_share_arb
    import cnna_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [P_W-1:0]         resp_data,
    output logic [ID_W-1:0]        resp_id,
`ifdef CNNA_MUL_SAT_EN
    output logic                   sat_flag,
`endif
    output logic [CNT_W-1:0]       op_cnt
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               resp_valid_q, resp_valid_d;
    logic [P_W-1:0]     resp_data_q, resp_data_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               can_acc;
    logic               xfer;
    logic [A_W-1:0]     a_sel;
    logic [B_W-1:0]     b_sel;
    logic [P_W-1:0]     prod;

    cnna_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i       (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // AND-OR operand mux on the one-hot grant.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel |= req_a[i*A_W +: A_W];
                b_sel |= req_b[i*B_W +: B_W];
            end
        end
    end

`ifdef CNNA_MUL_SAT_EN
    logic sat, sat_q, sat_d;

    cnna_mul_15x13 u_mul (
        .a_i   (a_sel),
        .b_i   (b_sel),
        .sat_o (sat),
        .p_o   (prod)
    );
`else
    cnna_mul_15x13 u_mul (
        .a_i (a_sel),
        .b_i (b_sel),
        .p_o (prod)
    );
`endif

    // Accept when the output register is empty or draining this cycle.
    assign can_acc   = !resp_valid_q || resp_ready;
    assign req_ready = ap_rst ? '0 : (grant & {NUM_REQ{can_acc}});
    assign xfer      = |(req_valid & req_ready);

    // Next-state: load on transfer, clear valid on drain, otherwise hold.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        op_cnt_d     = op_cnt_q;
`ifdef CNNA_MUL_SAT_EN
        sat_d        = sat_q;
`endif
        if (xfer) begin
            resp_valid_d = 1'b1;
            resp_data_d  = prod;
            resp_id_d    = grant_idx;
            rr_ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            op_cnt_d     = op_cnt_q + CNT_W'(1);
`ifdef CNNA_MUL_SAT_EN
            sat_d        = sat;
`endif
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            op_cnt_q     <= '0;
`ifdef CNNA_MUL_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            op_cnt_q     <= op_cnt_d;
`ifdef CNNA_MUL_SAT_EN
            sat_q        <= sat_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign op_cnt     = op_cnt_q;
`ifdef CNNA_MUL_SAT_EN
    assign sat_flag   = sat_q;
`endif

endmodule

// File: tb/tb_cnna_mul_share_arb.sv
// Scoreboard bench for cnna_mul_share_arb: stimulus pushes hand-computed
// responses into a queue, a negedge monitor pops one per output handshake.
// Honors CNNA_MUL_SAT_EN for the overflow vectors.
module tb_cnna_mul_share_arb;

`ifdef CNNA_MUL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [59:0] req_a;
    logic [51:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [1:0]  resp_id;
    logic [31:0] op_cnt;
`ifdef CNNA_MUL_SAT_EN
    logic        sat_flag;
`endif

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  id;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 ap_clk = ~ap_clk;

    cnna_mul_share_arb #(.NUM_REQ(4), .ID_W(2), .CNT_W(32)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
`ifdef CNNA_MUL_SAT_EN
        .sat_flag   (sat_flag),
`endif
        .op_cnt     (op_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [14:0] a, input logic [12:0] b);
        req_a[i*15 +: 15] = a;
        req_b[i*13 +: 13] = b;
    endtask

    function automatic exp_t mk(input logic [15:0] d, input logic [1:0] id, input logic s);
        exp_t e;
        e.data = d;
        e.id   = id;
        e.sat  = s;
        return e;
    endfunction

    // Monitor: one pop per completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst && resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got data 0x%0h id %0d, want no response",
                             resp_data, resp_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", 32'(resp_data), 32'(e.data));
                    chk("resp_id", 32'(resp_id), 32'(e.id));
`ifdef CNNA_MUL_SAT_EN
                    chk("sat_flag", 32'(sat_flag), 32'(e.sat));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // Overflow vectors: requester, a, b, truncated result.
    int          ov_i[4]    = '{0, 1, 3, 2};
    logic [14:0] ov_a[4]    = '{15'd20000, 15'd32767, 15'd256, 15'd32767};
    logic [12:0] ov_b[4]    = '{13'd5000, 13'd1, 13'd256, 13'd8191};
    logic [15:0] ov_t[4]    = '{16'hE100, 16'h7FFF, 16'h0000, 16'h6001};
    logic        ov_s[4]    = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] rr_prod[4] = '{16'd2000, 16'd3003, 16'd4008, 16'd5015};

    initial begin
        logic [3:0]  oh;
        logic [15:0] ed;
        ap_rst     = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #3;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_op_cnt", op_cnt, 0);
        step();
        step();
        ap_rst = 1'b0;

        // Idle after reset.
        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle_resp_valid", 32'(resp_valid), 0);
            chk("idle_req_ready", 32'(req_ready), 0);
            chk("idle_op_cnt", op_cnt, 0);
        end

        // Single requester 2: 300*7 = 2100.
        set_req(2, 15'd300, 13'd7);
        req_valid = 4'b0100;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h4);
        exp_q.push_back(mk(16'd2100, 2'd2, 1'b0));
        step();
        req_valid = '0;
        chk("single_resp_valid", 32'(resp_valid), 1);
        chk("single_op_cnt", op_cnt, 1);
        step();
        chk("drain_resp_valid", 32'(resp_valid), 0);
        chk("drain_hold_data", 32'(resp_data), 2100);
        chk("drain_hold_id", 32'(resp_id), 2);

        // Mid-stream reset with a stalled product in the output register.
        set_req(1, 15'd11, 13'd3);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        #1;
        chk("mid_req_ready", 32'(req_ready), 32'h2);
        step();
        chk("mid_resp_valid", 32'(resp_valid), 1);
        chk("mid_resp_data", 32'(resp_data), 33);
        chk("mid_op_cnt", op_cnt, 2);
        req_valid = 4'hF;
        #1;
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_resp_valid", 32'(resp_valid), 0);
        chk("mid_rst_op_cnt", op_cnt, 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_resp_data", 32'(resp_data), 0);
        step();
        ap_rst     = 1'b0;
        resp_ready = 1'b1;

        // All four requesting: rotation 0,1,2,3,... one product per cycle.
        for (int i = 0; i < 4; i++) set_req(i, 15'(1000 + i), 13'(2 + i));
        for (int k = 0; k < 8; k++) begin
            #1;
            oh = 4'(1 << (k % 4));
            chk("rr_req_ready", 32'(req_ready), 32'(oh));
            if (k > 0) chk("rr_no_gap", 32'(resp_valid), 1);
            exp_q.push_back(mk(rr_prod[k % 4], 2'(k % 4), 1'b0));
            step();
        end
        chk("rr_op_cnt", op_cnt, 8);

        // Backpressure: output and pointer frozen.
        resp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_resp_valid", 32'(resp_valid), 1);
            chk("bp_resp_data", 32'(resp_data), 5015);
            chk("bp_resp_id", 32'(resp_id), 3);
            step();
        end
        chk("bp_op_cnt", op_cnt, 8);
        resp_ready = 1'b1;
        #1;
        chk("bp_resume_grant", 32'(req_ready), 32'h1);
        exp_q.push_back(mk(16'd2000, 2'd0, 1'b0));
        step();
        req_valid = '0;
        chk("bp_resume_op_cnt", op_cnt, 9);
        step();

        // Overflow and boundary products, one requester at a time.
        for (int v = 0; v < 4; v++) begin
            set_req(ov_i[v], ov_a[v], ov_b[v]);
            req_valid = 4'(1 << ov_i[v]);
            #1;
            chk("ov_req_ready", 32'(req_ready), 32'(1 << ov_i[v]));
            ed = (SAT && ov_s[v]) ? 16'hFFFF : ov_t[v];
            exp_q.push_back(mk(ed, 2'(ov_i[v]), SAT && ov_s[v]));
            step();
            req_valid = '0;
        end
        chk("ov_op_cnt", op_cnt, 13);

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("final_resp_valid", 32'(resp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cnna_mul_share_arb.md
Name: cnna_mul_share_arb

Overview:
- Round-robin arbiter sharing one unsigned 15x13-bit multiplier among NUM_REQ requesters in the cnna compute array.
- Each requester presents an operand pair with a valid/ready handshake. The winning pair is multiplied and the 16-bit product is registered onto a single response channel tagged with the requester index.
- Sits between the per-channel scale/offset stages and the shared multiplier slice, so one multiplier serves several channels.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the response tag; must equal ceil(log2(NUM_REQ)).
- CNT_W, 32, width of the accepted-operation counter.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*15  packed unsigned multiplicands; requester i occupies bits [15i+14:15i].
- req_b  in  NUM_REQ*13  packed unsigned multipliers; requester i occupies bits [13i+12:13i].
- resp_valid  out  1  product valid.
- resp_ready  in  1  downstream accept.
- resp_data  out  16  product.
- resp_id  out  ID_W  index of the requester that produced resp_data.
- op_cnt  out  CNT_W  total accepted operations; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, ap_rst=1):
  - resp_valid=0, resp_data=0, resp_id=0, op_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready is all-zero while reset is asserted.
- Accept condition: can_acc = !resp_valid || resp_ready (output register empty or draining this cycle).
- Grant (combinational):
  - Search starts at rr_ptr and moves upward with wrap, e.g. rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ..., rr_ptr-1.
  - The first index with req_valid set wins. grant is one-hot or zero.
  - req_ready = grant & {NUM_REQ{can_acc}}.
  - Requesters must hold req_valid and operands stable until req_ready. Dropping valid before ready is legal; the arbiter simply re-arbitrates.
- Transfer: a transfer happens on the cycle where req_valid[i] && req_ready[i]. On the next edge:
  - resp_data <= product(i), resp_id <= i, resp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - op_cnt <= op_cnt+1.
- Latency is 1 cycle from accept to resp_valid.
- Throughput is 1 product per cycle while resp_ready=1.
- No transfer this cycle:
  - If resp_valid && resp_ready: resp_valid <= 0; resp_data and resp_id hold their last value.
  - If resp_valid && !resp_ready: output holds. All req_ready are 0 (backpressure) and rr_ptr does not move.
- Simultaneous drain and accept in the same cycle: the new product replaces the old one and resp_valid stays 1. There is no bubble.
- Arithmetic: the full product a*b is 28 bits unsigned. By default resp_data = product[15:0] (truncation, modulo 2^16).
- Fairness: every continuously requesting requester is granted within NUM_REQ accepts.
- No requests: rr_ptr holds and the output simply drains.
- Reset mid-operation: an in-flight product is discarded; nothing is replayed.

Optional Feature:
- Macro: CNNA_MUL_SAT_EN.
- Defined: if product[27:16] != 0, resp_data = 16'hFFFF; otherwise resp_data = product[15:0]. Additional output port sat_flag (out, 1): registered alongside resp_data, set when saturation occurred, reset value 0.
- Undefined: pure truncation, and the sat_flag port does not exist.

Decomposition:
- Package cnna_mul_arb_pkg holds:
  - Constants A_W=15, B_W=13, P_W=16, FULL_W=28.
  - The ID_W helper function (clog2).
  - The one-hot-to-index function.
- Sub-module cnna_rr_pick(NUM_REQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and binary grant index.
  - Purely combinational, rotate/priority/rotate-back.
- The multiplier itself is the team's existing single-stage cnna 15ns x 13ns -> 16 multiplier block, instantiated once on the muxed operands.

Test Plan:
- Reset release, all req_valid=0 -> resp_valid=0, req_ready=0000, op_cnt=0 for 10 cycles.
- Single requester: req 2 with a=300, b=7, resp_ready=1 -> req_ready=0100 that cycle; next cycle resp_valid=1, resp_data=2100, resp_id=2, op_cnt=1.
- All 4 requesters valid continuously, resp_ready=1 -> grant order 0,1,2,3,0,1,... with one product per cycle and no gaps.
- Backpressure: resp_ready=0 with resp_valid=1 for 5 cycles -> req_ready=0000, resp_data/resp_id stable, rr_ptr unchanged; after resp_ready=1, the next grant continues the rotation.
- Overflow: a=20000, b=5000 -> resp_data=16'hE100 without the macro; with CNNA_MUL_SAT_EN, resp_data=16'hFFFF and sat_flag=1. a=32767, b=1 -> resp_data=16'h7FFF in both builds, sat_flag=0.
- Mid-stream reset: assert ap_rst while resp_valid=1 -> resp_valid drops immediately (asynchronous), op_cnt=0, and after release the first grant goes to requester 0.
